// File: rtl/pipe_pkg.sv
// pipe_pkg: control-bundle bit map, defaults and update-mode encoding shared by the ID/EX stage.
package pipe_pkg;
    localparam int XLEN_DEF   = 32;
    localparam int CTRL_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;
    localparam int REGWRITE   = 0;
    localparam int MEMREAD    = 1;
    localparam int MEMWRITE   = 2;
    localparam int MEMTOREG   = 3;
    localparam int BRANCH     = 4;
    localparam int ALUSRC     = 5;
    localparam int ALUOP_LO   = 6;
    localparam int ALUOP_HI   = 7;
    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;
    typedef enum logic [1:0] {
        UPD_LOAD,
        UPD_HOLD,
        UPD_BUBBLE,
        UPD_FLUSH
    } upd_e;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use detection; stall is suppressed by flush or a global hold.
module hazard_detect (
    input  logic       mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       uses_rs2,
    input  logic       flush,
    input  logic       hold,
    output logic       load_use,
    output logic       stall
);
    always_comb begin
        load_use = mem_read && ex_rd != 5'd0 && (ex_rd == rs1 || (uses_rs2 && ex_rd == rs2));
        stall    = load_use && !flush && !hold;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubbles, branch flush, WB->ID bypass
// and saturating stall/flush counters.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        IF_ID_Rs1,
    input  logic [4:0]        IF_ID_Rs2,
    input  logic [4:0]        IF_ID_Rd,
    input  logic              IF_ID_UsesRs2,
    input  logic [XLEN-1:0]   IF_ID_PC,
    input  logic [XLEN-1:0]   IF_ID_Imm,
    input  logic [3:0]        IF_ID_Funct,
    input  logic [CTRL_W-1:0] IF_ID_Ctrl,
    input  logic [XLEN-1:0]   RF_Data1,
    input  logic [XLEN-1:0]   RF_Data2,
    input  logic              MEM_WB_RegWrite,
    input  logic [4:0]        MEM_WB_Rd,
    input  logic [XLEN-1:0]   MEM_WB_Data,
    input  logic              flush,
    input  logic              hold,
    output logic [4:0]        ID_EX_Rs1,
    output logic [4:0]        ID_EX_Rs2,
    output logic [4:0]        ID_EX_Rd,
    output logic [XLEN-1:0]   ID_EX_PC,
    output logic [XLEN-1:0]   ID_EX_Imm,
    output logic [3:0]        ID_EX_Funct,
    output logic [CTRL_W-1:0] ID_EX_Ctrl,
    output logic [XLEN-1:0]   ID_EX_Data1,
    output logic [XLEN-1:0]   ID_EX_Data2,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    logic            load_use;
    logic            kill;
    upd_e            upd;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;

    hazard_detect u_hazard (
        .mem_read (ID_EX_Ctrl[MEMREAD]),
        .ex_rd    (ID_EX_Rd),
        .rs1      (IF_ID_Rs1),
        .rs2      (IF_ID_Rs2),
        .uses_rs2 (IF_ID_UsesRs2),
        .flush    (flush),
        .hold     (hold),
        .load_use (load_use),
        .stall    (stall)
    );

    always_comb begin
        upd   = flush ? UPD_FLUSH : hold ? UPD_HOLD : load_use ? UPD_BUBBLE : UPD_LOAD;
        kill  = upd == UPD_FLUSH || upd == UPD_BUBBLE;
        data1 = (MEM_WB_RegWrite && MEM_WB_Rd != 5'd0 && MEM_WB_Rd == IF_ID_Rs1) ? MEM_WB_Data : RF_Data1;
        data2 = (MEM_WB_RegWrite && MEM_WB_Rd != 5'd0 && MEM_WB_Rd == IF_ID_Rs2) ? MEM_WB_Data : RF_Data2;
    end

    // Killed slots also clear the register indices so EX forwarding never matches a dead producer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ID_EX_Rs1   <= '0;
            ID_EX_Rs2   <= '0;
            ID_EX_Rd    <= '0;
            ID_EX_PC    <= '0;
            ID_EX_Imm   <= '0;
            ID_EX_Funct <= '0;
            ID_EX_Ctrl  <= '0;
            ID_EX_Data1 <= '0;
            ID_EX_Data2 <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (upd != UPD_HOLD) begin
            ID_EX_Rs1   <= kill ? 5'd0 : IF_ID_Rs1;
            ID_EX_Rs2   <= kill ? 5'd0 : IF_ID_Rs2;
            ID_EX_Rd    <= kill ? 5'd0 : IF_ID_Rd;
            ID_EX_Ctrl  <= kill ? CTRL_W'(CTRL_NOP) : IF_ID_Ctrl;
            ID_EX_PC    <= IF_ID_PC;
            ID_EX_Imm   <= IF_ID_Imm;
            ID_EX_Funct <= IF_ID_Funct;
            ID_EX_Data1 <= data1;
            ID_EX_Data2 <= data2;
            stall_count <= (upd == UPD_BUBBLE && !(&stall_count)) ? stall_count + 1'b1 : stall_count;
            flush_count <= (upd == UPD_FLUSH && !(&flush_count)) ? flush_count + 1'b1 : flush_count;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed stimulus with a queued scoreboard; a narrow-counter twin exercises saturation.
module tb_id_ex_stage;
    localparam logic [7:0] LW   = 8'h2B;
    localparam logic [7:0] ADD  = 8'h81;
    localparam logic [7:0] ADDI = 8'h21;

    typedef struct {
        logic        stall;
        logic [7:0]  ctrl;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, pc, imm;
        logic [3:0]  funct;
        int          sc, fc;
        bit          full;
    } exp_t;

    logic clk = 1'b0;
    logic rst, u2, wb_we, flush, hold;
    logic [4:0] rs1, rs2, rd, wb_rd;
    logic [31:0] pc, imm, d1, d2, wb_data;
    logic [3:0] funct;
    logic [7:0] ctrl;

    logic [4:0]  o_rs1, o_rs2, o_rd, s_rs1, s_rs2, s_rd;
    logic [31:0] o_pc, o_imm, o_d1, o_d2, s_pc, s_imm, s_d1, s_d2;
    logic [3:0]  o_funct, s_funct;
    logic [7:0]  o_ctrl, s_ctrl;
    logic        o_stall, s_stall;
    logic [15:0] o_sc, o_fc;
    logic [2:0]  s_sc, s_fc;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_Rd(rd),
        .IF_ID_UsesRs2(u2), .IF_ID_PC(pc), .IF_ID_Imm(imm), .IF_ID_Funct(funct),
        .IF_ID_Ctrl(ctrl), .RF_Data1(d1), .RF_Data2(d2), .MEM_WB_RegWrite(wb_we),
        .MEM_WB_Rd(wb_rd), .MEM_WB_Data(wb_data), .flush(flush), .hold(hold),
        .ID_EX_Rs1(o_rs1), .ID_EX_Rs2(o_rs2), .ID_EX_Rd(o_rd), .ID_EX_PC(o_pc),
        .ID_EX_Imm(o_imm), .ID_EX_Funct(o_funct), .ID_EX_Ctrl(o_ctrl),
        .ID_EX_Data1(o_d1), .ID_EX_Data2(o_d2), .stall(o_stall),
        .stall_count(o_sc), .flush_count(o_fc)
    );

    id_ex_stage #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_Rd(rd),
        .IF_ID_UsesRs2(u2), .IF_ID_PC(pc), .IF_ID_Imm(imm), .IF_ID_Funct(funct),
        .IF_ID_Ctrl(ctrl), .RF_Data1(d1), .RF_Data2(d2), .MEM_WB_RegWrite(wb_we),
        .MEM_WB_Rd(wb_rd), .MEM_WB_Data(wb_data), .flush(flush), .hold(hold),
        .ID_EX_Rs1(s_rs1), .ID_EX_Rs2(s_rs2), .ID_EX_Rd(s_rd), .ID_EX_PC(s_pc),
        .ID_EX_Imm(s_imm), .ID_EX_Funct(s_funct), .ID_EX_Ctrl(s_ctrl),
        .ID_EX_Data1(s_d1), .ID_EX_Data2(s_d2), .stall(s_stall),
        .stall_count(s_sc), .flush_count(s_fc)
    );

    function automatic exp_t mk(bit st, logic [7:0] c, logic [4:0] a, logic [4:0] b, logic [4:0] d,
                                logic [31:0] x, logic [31:0] y, int tag, int sc, int fc, bit full);
        exp_t e;
        e.stall = st; e.ctrl = c; e.rs1 = a; e.rs2 = b; e.rd = d; e.d1 = x; e.d2 = y;
        e.pc = 32'h1000 * tag; e.imm = tag * 3; e.funct = 4'(tag);
        e.sc = sc; e.fc = fc; e.full = full;
        return e;
    endfunction

    function automatic int sat7(int v);
        return v > 7 ? 7 : v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, want, $time);
        end
    endtask

    task automatic drv(int tag, logic [4:0] a, logic [4:0] b, logic [4:0] d, logic use2,
                       logic [7:0] c, logic [31:0] x, logic [31:0] y);
        rs1 = a; rs2 = b; rd = d; u2 = use2; ctrl = c; d1 = x; d2 = y;
        pc = 32'h1000 * tag; imm = tag * 3; funct = 4'(tag);
    endtask

    task automatic step(exp_t e);
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: stall is checked mid-cycle before the edge, registers just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("stall", o_stall, e.stall);
                chk("stall_narrow", s_stall, e.stall);
                @(posedge clk);
                #1;
                chk("ctrl", o_ctrl, e.ctrl);
                chk("ctrl_narrow", s_ctrl, e.ctrl);
                chk("rs1", o_rs1, e.rs1);
                chk("rs2", o_rs2, e.rs2);
                chk("rd", o_rd, e.rd);
                chk("rd_narrow", s_rd, e.rd);
                chk("stall_count", o_sc, e.sc);
                chk("flush_count", o_fc, e.fc);
                chk("stall_count_sat", s_sc, sat7(e.sc));
                chk("flush_count_sat", s_fc, sat7(e.fc));
                if (e.full) begin
                    chk("data1", o_d1, e.d1);
                    chk("data2", o_d2, e.d2);
                    chk("pc", o_pc, e.pc);
                    chk("imm", o_imm, e.imm);
                    chk("funct", o_funct, e.funct);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drv(15, 1, 2, 3, 1, LW, 32'h5A, 32'hA5);
        rst = 1; flush = 1; hold = 1; wb_we = 1; wb_rd = 3; wb_data = 32'h1;
        @(posedge clk);
        #2;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rst = 0; flush = 0; hold = 0; wb_we = 0;
        // load-use on rs1, then the dependent add loads
        drv(1, 1, 0, 5, 0, LW, 32'h100, 32'h200);
        step(mk(0, LW, 1, 0, 5, 32'h100, 32'h200, 1, 0, 0, 1));
        drv(2, 5, 7, 6, 1, ADD, 32'h55, 32'h77);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        step(mk(0, ADD, 5, 7, 6, 32'h55, 32'h77, 2, 1, 0, 1));
        // I-type: rs2 matches but is not read
        drv(3, 2, 0, 5, 0, LW, 32'h300, 32'h400);
        step(mk(0, LW, 2, 0, 5, 32'h300, 32'h400, 3, 1, 0, 1));
        drv(4, 9, 5, 6, 0, ADDI, 32'h9, 32'h5);
        step(mk(0, ADDI, 9, 5, 6, 32'h9, 32'h5, 4, 1, 0, 1));
        // WB bypass on rs1, x0 never bypassed, bypass on rs2
        wb_we = 1; wb_rd = 3; wb_data = 32'hDEADBEEF;
        drv(5, 3, 4, 8, 1, ADD, 32'h11, 32'h22);
        step(mk(0, ADD, 3, 4, 8, 32'hDEADBEEF, 32'h22, 5, 1, 0, 1));
        wb_rd = 0;
        drv(6, 0, 0, 9, 1, ADD, 32'h33, 32'h44);
        step(mk(0, ADD, 0, 0, 9, 32'h33, 32'h44, 6, 1, 0, 1));
        wb_rd = 4; wb_data = 32'hCAFEF00D;
        drv(7, 1, 4, 10, 1, ADD, 32'h66, 32'h77);
        step(mk(0, ADD, 1, 4, 10, 32'h66, 32'hCAFEF00D, 7, 1, 0, 1));
        wb_we = 0;
        // flush together with load-use
        drv(8, 1, 0, 5, 0, LW, 32'h80, 32'h81);
        step(mk(0, LW, 1, 0, 5, 32'h80, 32'h81, 8, 1, 0, 1));
        flush = 1;
        drv(9, 5, 0, 7, 0, ADD, 32'h90, 32'h91);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        flush = 0;
        // hold during load-use, then one bubble on release
        drv(10, 1, 0, 5, 0, LW, 32'hA0, 32'hA1);
        step(mk(0, LW, 1, 0, 5, 32'hA0, 32'hA1, 10, 1, 1, 1));
        hold = 1;
        drv(11, 5, 7, 6, 1, ADD, 32'hB0, 32'hB1);
        for (int i = 0; i < 3; i++) step(mk(0, LW, 1, 0, 5, 32'hA0, 32'hA1, 10, 1, 1, 1));
        hold = 0;
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        step(mk(0, ADD, 5, 7, 6, 32'hB0, 32'hB1, 11, 2, 1, 1));
        // push stall count past the narrow counter's limit
        for (int i = 0; i < 6; i++) begin
            drv(20 + i, 1, 0, 5, 0, LW, i, i + 1);
            step(mk(0, LW, 1, 0, 5, i, i + 1, 20 + i, 2 + i, 1, 1));
            drv(40 + i, 5, 7, 6, 1, ADD, 32'h500 + i, 32'h600 + i);
            step(mk(1, 0, 0, 0, 0, 0, 0, 0, 3 + i, 1, 0));
            step(mk(0, ADD, 5, 7, 6, 32'h500 + i, 32'h600 + i, 40 + i, 3 + i, 1, 1));
        end
        flush = 1;
        for (int j = 0; j < 8; j++) begin
            drv(60 + j, 5, 7, 6, 1, ADD, j, j);
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 8, 2 + j, 0));
        end
        flush = 0;
        // reset while a load-use is pending drops the bubble
        drv(70, 1, 0, 5, 0, LW, 32'hC8, 32'hC9);
        step(mk(0, LW, 1, 0, 5, 32'hC8, 32'hC9, 70, 8, 9, 1));
        drv(71, 5, 7, 6, 1, ADD, 32'hC0, 32'hC1);
        rst = 1;
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rst = 0;
        step(mk(0, ADD, 5, 7, 6, 32'hC0, 32'hC1, 71, 0, 0, 1));
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
